// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding select encoding and
// the mul/div sequencing FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RD = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } forward_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdiv_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding compare: picks the youngest in-flight producer of
// the E-stage source register. M beats W, register 0 never forwards.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rd_m,
    input  logic [ADDR_W-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RD;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load-use and branch
// stall/flush, and a busy FSM holding a multi-cycle mul/div in E.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MDIV_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      ResultSrcE0,
    input  logic                      PCSrcE,
    input  logic                      MulDivE,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic                      MulDivBusy,
    output mdiv_state_t               dbg_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               StallCount,
    output logic [31:0]               FlushCount
`endif
);

    localparam int CNT_W = $clog2(MDIV_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (MDIV_LATENCY > 2) ? CNT_W'(MDIV_LATENCY - 2) : '0;

    mdiv_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done, done_n;
    logic             mdiv_start;
    logic             busy_win;
    logic             lw_stall;
    logic             branch;

    fwd_sel #(.ADDR_W(REG_ADDR_WIDTH)) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardAE)
    );

    fwd_sel #(.ADDR_W(REG_ADDR_WIDTH)) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardBE)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            done  <= done_n;
        end
    end

    // done marks the final E cycle of a finished mul/div, whose MulDivE is
    // still high, so it must not start a second stall window.
    always_comb begin
        mdiv_start = (state == MD_IDLE) && MulDivE && !done && (MDIV_LATENCY > 1);
        state_n    = state;
        cnt_n      = cnt;
        done_n     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (mdiv_start) begin
                    if (MDIV_LATENCY > 2) begin
                        state_n = MD_BUSY;
                        cnt_n   = CNT_LOAD;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            MD_BUSY: begin
                // Leave once the count decrements to zero; this cycle still stalls.
                if (cnt <= CNT_W'(1)) begin
                    cnt_n   = '0;
                    state_n = MD_IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = MD_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        busy_win = !rst && ((state == MD_BUSY) || mdiv_start);
        lw_stall = !rst && (state == MD_IDLE) && !mdiv_start && !PCSrcE &&
                   ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
        branch   = !rst && (state == MD_IDLE) && !mdiv_start && PCSrcE;

        StallF     = busy_win || lw_stall;
        StallD     = busy_win || lw_stall;
        StallE     = busy_win;
        FlushD     = branch;
        FlushE     = branch || lw_stall;
        FlushM     = busy_win;
        MulDivBusy = busy_win;
        dbg_state  = state;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((FlushD || FlushE) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vectors plus a cycle-level reference model
// of the hazard rules compared against the DUT on every falling edge.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy;
    mdiv_state_t   dbg_state;
`ifdef HAZARD_PERF_EN
    logic [31:0]   StallCount, FlushCount;
`endif

    int compared;
    int mismatched;
    int age;
    logic stim_done;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MDIV_LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .MulDivE     (MulDivE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .MulDivBusy  (MulDivBusy),
        .dbg_state   (dbg_state)
`ifdef HAZARD_PERF_EN
        ,
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [AW-1:0] rs);
        if (RegWriteM && (RdM != 0) && (RdM == rs)) return 2'b10;
        if (RegWriteW && (RdW != 0) && (RdW == rs)) return 2'b01;
        return 2'b00;
    endfunction

    // Reference: a mul/div sits LAT cycles in E and the first LAT-1 stall.
    task automatic compare_cycle();
        logic busy_x, lw_x, br_x;
        busy_x = !rst && MulDivE && (age < LAT - 1);
        lw_x   = !rst && !busy_x && !PCSrcE && ResultSrcE0 && (RdE != 0) &&
                 ((Rs1D == RdE) || (Rs2D == RdE));
        br_x   = !rst && !busy_x && PCSrcE;
        check("cyc_fwd_a",  32'(ForwardAE),  32'(fwd_model(Rs1E)));
        check("cyc_fwd_b",  32'(ForwardBE),  32'(fwd_model(Rs2E)));
        check("cyc_stallf", 32'(StallF),     32'(busy_x || lw_x));
        check("cyc_stalld", 32'(StallD),     32'(busy_x || lw_x));
        check("cyc_stalle", 32'(StallE),     32'(busy_x));
        check("cyc_flushd", 32'(FlushD),     32'(br_x));
        check("cyc_flushe", 32'(FlushE),     32'(br_x || lw_x));
        check("cyc_flushm", 32'(FlushM),     32'(busy_x));
        check("cyc_busy",   32'(MulDivBusy), 32'(busy_x));
    endtask

    task automatic model_advance();
        if (rst || !MulDivE) age = 0;
        else age = (age + 1 == LAT) ? 0 : age + 1;
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MulDivE = 1'b0;
    endtask

    task automatic run_stimulus();
        int stalle_n;
        int busy_n;
        int stallf_n;

        // reset state
        tick();
        check("rst_stallf", 32'(StallF), 32'd0);
        check("rst_flushm", 32'(FlushM), 32'd0);
        check("rst_state",  32'(dbg_state), 32'(MD_IDLE));
        rst = 1'b0;
        tick();

        // forwarding: M beats W, then W, then register zero
        RdM = 5; RegWriteM = 1'b1; RdW = 5; RegWriteW = 1'b1; Rs1E = 5; Rs2E = 5;
        #1;
        check("fwd_a_m", 32'(ForwardAE), 32'h2);
        check("fwd_b_m", 32'(ForwardBE), 32'h2);
        tick();
        RegWriteM = 1'b0;
        #1;
        check("fwd_a_w", 32'(ForwardAE), 32'h1);
        tick();
        RegWriteM = 1'b1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 3;
        #1;
        check("fwd_a_zero", 32'(ForwardAE), 32'h0);
        check("fwd_b_none", 32'(ForwardBE), 32'h0);
        tick();
        clear_inputs();

        // load-use: single-cycle bubble
        ResultSrcE0 = 1'b1; RdE = 7; Rs2D = 7;
        #1;
        check("lw_stallf", 32'(StallF), 32'd1);
        check("lw_stalld", 32'(StallD), 32'd1);
        check("lw_flushe", 32'(FlushE), 32'd1);
        check("lw_stalle", 32'(StallE), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("lw_one_cycle", 32'(StallF), 32'd0);
        tick();
        ResultSrcE0 = 1'b1; RdE = 0; Rs2D = 0;
        #1;
        check("lw_x0_nostall", 32'(StallF), 32'd0);
        tick();

        // load-use suppressed by a taken branch
        ResultSrcE0 = 1'b1; RdE = 9; Rs1D = 9; PCSrcE = 1'b1;
        #1;
        check("br_flushd", 32'(FlushD), 32'd1);
        check("br_flushe", 32'(FlushE), 32'd1);
        check("br_stallf", 32'(StallF), 32'd0);
        check("br_stalld", 32'(StallD), 32'd0);
        tick();
        clear_inputs();
        tick();
`ifdef HAZARD_PERF_EN
        check("perf_stall", StallCount, 32'd1);
        check("perf_flush", FlushCount, 32'd2);
`endif

        // mul/div window with a branch pulse inside it
        stalle_n = 0; busy_n = 0; stallf_n = 0;
        MulDivE = 1'b1;
        for (int c = 0; c < LAT; c++) begin
            PCSrcE = (c == 1);
            #1;
            if (StallE) stalle_n++;
            if (MulDivBusy) busy_n++;
            if (StallF && StallD && FlushM) stallf_n++;
            if (c == 1) check("md_branch_ignored", 32'(FlushD), 32'd0);
            tick();
        end
        MulDivE = 1'b0; PCSrcE = 1'b0;
        #1;
        check("md_stalle_cycles", 32'(stalle_n), 32'(LAT - 1));
        check("md_busy_cycles",   32'(busy_n),   32'(LAT - 1));
        check("md_stall_cycles",  32'(stallf_n), 32'(LAT - 1));
        check("md_state_idle",    32'(dbg_state), 32'(MD_IDLE));
        tick();

        // asynchronous reset during the second BUSY cycle
        MulDivE = 1'b1;
        tick();
        tick();
        #2;
        check("ab_pre_busy", 32'(dbg_state), 32'(MD_BUSY));
        rst = 1'b1;
        #1;
        check("ab_stalle", 32'(StallE), 32'd0);
        check("ab_stallf", 32'(StallF), 32'd0);
        check("ab_flushm", 32'(FlushM), 32'd0);
        check("ab_busy",   32'(MulDivBusy), 32'd0);
        check("ab_state",  32'(dbg_state), 32'(MD_IDLE));
        tick();
        rst = 1'b0; MulDivE = 1'b0;
        #1;
        check("ab_after_state", 32'(dbg_state), 32'(MD_IDLE));
        check("ab_after_stall", 32'(StallE), 32'd0);
        tick();

        // short mixed burst: small register range forces collisions
        for (int i = 0; i < 24; i++) begin
            Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
            Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
            RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
            RdW  = AW'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            ResultSrcE0 = 1'($urandom_range(0, 1));
            PCSrcE = ($urandom_range(0, 3) == 0);
            tick();
        end
        clear_inputs();
        tick();
        stim_done = 1'b1;
    endtask

    // compare process: model checked on the falling edge, advanced on the rising edge
    task automatic compare_loop();
        while (!stim_done) begin
            @(negedge clk);
            compare_cycle();
            @(posedge clk);
            model_advance();
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        age        = 0;
        stim_done  = 1'b0;
        rst        = 1'b1;
        clear_inputs();
        fork
            run_stimulus();
            compare_loop();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
